afifo_write_arbiter: RTL and testbench

//  Shares the single write port of async_fifo among N requesters in the WCLK domain.

---
 rtl/afifo_write_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_afifo_write_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/afifo_write_arbiter.sv
// afifo_write_arbiter: round-robin share of the async_fifo write port among N
// requesters in the WCLK domain. A single registered output stage holds the
// granted word until the FIFO takes it, so words are never lost or duplicated.
// Optional feature macro: AFW_BURST_EN. When it is defined, a granted requester
// keeps the port for up to BURST_LEN consecutive words.
module afifo_write_arbiter #(
    parameter int N         = 4,
    parameter int W         = 32,
    parameter int IDW       = $clog2(N),
    parameter int BURST_LEN = 4
) (
    input  logic             WCLK,
    input  logic             RST,
    input  logic [N-1:0]     req_valid,
    input  logic [N*W-1:0]   req_data,
    output logic [N-1:0]     req_ready,
    input  logic             fifo_full,
    output logic [W-1:0]     fifo_din,
    output logic             fifo_we,
    output logic [IDW-1:0]   grant_id,
    output logic [31:0]      wr_count
);

    // Elaboration-time guard on the supported parameter ranges
    if (N < 2 || N > 16 || IDW != $clog2(N) || BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_params
        $error("afifo_write_arbiter: parameter out of range");
    end

    // Next requester index, wrapping at N (N need not be a power of two)
    function automatic logic [IDW-1:0] inc_mod(input logic [IDW-1:0] i);
        if (int'(i) == N - 1) return '0;
        return i + IDW'(1);
    endfunction

    // Output stage and pointer state
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_data_q,  out_data_d;
    logic [IDW-1:0] grant_id_q,  grant_id_d;
    logic [31:0]    wr_count_q,  wr_count_d;
    logic [IDW-1:0] rr_ptr_q,    rr_ptr_d;

    // Arbitration signals
    logic [N-1:0]   cand;
    logic [IDW-1:0] winner;
    logic [W-1:0]   sel_data;
    logic           can_accept;
    logic           accept;

    // The FIFO takes the held word whenever it has room
    always_comb begin
        fifo_we    = out_valid_q & ~fifo_full;
        can_accept = ~out_valid_q | fifo_we;
        fifo_din   = out_data_q;
        grant_id   = grant_id_q;
        wr_count   = wr_count_q;
    end

`ifdef AFW_BURST_EN
    typedef enum logic {IDLE, LOCK} state_t;

    state_t         state_q,     state_d;
    logic [IDW-1:0] owner_q,     owner_d;
    logic [7:0]     burst_cnt_q, burst_cnt_d;
    logic [N-1:0]   owner_oh;

    // While locked, only the owner is visible to the arbiter
    always_comb begin
        owner_oh = '0;
        for (int i = 0; i < N; i++) begin
            owner_oh[i] = (owner_q == IDW'(i));
        end
        cand = (state_q == LOCK) ? (req_valid & owner_oh) : req_valid;
    end
`else
    // Every valid requester competes on every cycle
    always_comb begin
        cand = req_valid;
    end
`endif

    // Round-robin pick: first candidate at or after rr_ptr, scanning upward mod N
    always_comb begin
        logic [IDW-1:0] idx;
        idx    = '0;
        winner = rr_ptr_q;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IDW'((int'(rr_ptr_q) + k) % N);
            if (cand[idx]) winner = idx;
        end
    end

    // One-hot ready to the winner, data mux from the winner
    always_comb begin
        accept    = can_accept & (|cand) & ~RST;
        req_ready = '0;
        sel_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (winner == IDW'(i)) begin
                req_ready[i] = accept;
                sel_data     = req_data[i*W +: W];
            end
        end
    end

    // Output-stage next state: load on accept, empty on a write with no refill
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        grant_id_d  = grant_id_q;
        wr_count_d  = fifo_we ? wr_count_q + 32'd1 : wr_count_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            grant_id_d  = winner;
        end else if (fifo_we) begin
            out_valid_d = 1'b0;
        end
        if (RST) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            grant_id_d  = '0;
            wr_count_d  = '0;
        end
    end

`ifdef AFW_BURST_EN
    // Burst FSM: an IDLE grant locks the port to its owner; the pointer only
    // moves past the owner on release. A full FIFO never forces a release.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (BURST_LEN > 1) begin
                        owner_d     = winner;
                        burst_cnt_d = 8'd1;
                        state_d     = LOCK;
                    end else begin
                        rr_ptr_d = inc_mod(winner);
                    end
                end
            end
            LOCK: begin
                if (accept) begin
                    if (int'(burst_cnt_q) + 1 >= BURST_LEN) begin
                        state_d     = IDLE;
                        burst_cnt_d = '0;
                        rr_ptr_d    = inc_mod(owner_q);
                    end else begin
                        burst_cnt_d = burst_cnt_q + 8'd1;
                    end
                end else if (can_accept && !req_valid[owner_q]) begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                    rr_ptr_d    = inc_mod(owner_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (RST) begin
            state_d     = IDLE;
            owner_d     = '0;
            burst_cnt_d = '0;
            rr_ptr_d    = '0;
        end
    end

    // Burst FSM registers
    always_ff @(posedge WCLK) begin
        state_q     <= state_d;
        owner_q     <= owner_d;
        burst_cnt_q <= burst_cnt_d;
    end
`else
    // Plain round robin: the pointer moves past every winner
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) rr_ptr_d = inc_mod(winner);
        if (RST)    rr_ptr_d = '0;
    end
`endif

    // Output stage and pointer registers (reset is folded into the _d logic)
    always_ff @(posedge WCLK) begin
        out_valid_q <= out_valid_d;
        out_data_q  <= out_data_d;
        grant_id_q  <= grant_id_d;
        wr_count_q  <= wr_count_d;
        rr_ptr_q    <= rr_ptr_d;
    end

endmodule

// File: tb/tb_afifo_write_arbiter.sv
// Directed bench for afifo_write_arbiter (N=4, W=32). Requesters are modelled
// as per-id source queues; the expected write order is pushed when stimulus is
// loaded and popped each time the DUT writes the FIFO.
module tb_afifo_write_arbiter;
    localparam int N   = 4;
    localparam int W   = 32;
    localparam int IDW = 2;

    logic             WCLK = 1'b0;
    logic             RST;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             fifo_full;
    logic [W-1:0]     fifo_din;
    logic             fifo_we;
    logic [IDW-1:0]   grant_id;
    logic [31:0]      wr_count;

    afifo_write_arbiter #(.N(N), .W(W), .IDW(IDW), .BURST_LEN(4)) dut (
        .WCLK(WCLK), .RST(RST), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_din(fifo_din),
        .fifo_we(fifo_we), .grant_id(grant_id), .wr_count(wr_count)
    );

    always #10 WCLK = ~WCLK;

    typedef struct {
        logic [IDW-1:0] id;
        logic [W-1:0]   data;
    } exp_t;

    int           checks   = 0;
    int           failures = 0;
    exp_t         exp_q[$];
    logic [W-1:0] src_q[N][$];
    logic         last_we;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] word(input int id, input int seq);
        return W'((id << 16) | seq);
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = (src_q[i].size() != 0);
            req_data[i*W +: W]  = (src_q[i].size() != 0) ? src_q[i][0] : '0;
        end
    endtask

    task automatic load(input int id, input int seq);
        src_q[id].push_back(word(id, seq));
        drive();
    endtask

    task automatic expw(input int id, input int seq);
        exp_t e;
        e.id   = IDW'(id);
        e.data = word(id, seq);
        exp_q.push_back(e);
    endtask

    // One clock: check any write at mid-cycle, then retire accepted words
    task automatic cycle();
        logic [N-1:0] acc;
        exp_t         e;
        @(negedge WCLK);
        last_we = fifo_we;
        if (fifo_we === 1'b1) begin
            chk("write_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_id", 64'(grant_id), 64'(e.id));
                chk("wr_data", 64'(fifo_din), 64'(e.data));
            end
        end
        acc = req_valid & req_ready;
        @(posedge WCLK);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) void'(src_q[i].pop_front());
        end
        drive();
    endtask

    initial begin
        RST       = 1'b1;
        fifo_full = 1'b0;
        req_valid = '0;
        req_data  = '0;
        repeat (20) @(posedge WCLK);
        #1 RST = 1'b0;

        // T1: idle after reset
        @(negedge WCLK);
        chk("t1_fifo_we", 64'(fifo_we), 64'd0);
        chk("t1_wr_count", 64'(wr_count), 64'd0);
        chk("t1_grant_id", 64'(grant_id), 64'd0);
        chk("t1_req_ready", 64'(req_ready), 64'd0);
        @(posedge WCLK);
        #1;

`ifndef AFW_BURST_EN
        // T2: all valid, ids in round-robin order, one write per cycle after the first
        for (int s = 0; s < 2; s++)
            for (int id = 0; id < N; id++) begin
                load(id, s);
                expw(id, s);
            end
        cycle();
        chk("t2_first_we", 64'(last_we), 64'd0);
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("t2_we_stream", 64'(last_we), 64'd1);
        end
        chk("t2_drained", 64'(exp_q.size()), 64'd0);
        chk("t2_wr_count", 64'(wr_count), 64'd8);

        // T3: FIFO full holds the word and blocks all grants
        for (int s = 2; s < 4; s++)
            for (int id = 0; id < N; id++) begin
                load(id, s);
                expw(id, s);
            end
        cycle();
        fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge WCLK);
            chk("t3_we_blocked", 64'(fifo_we), 64'd0);
            chk("t3_ready_blocked", 64'(req_ready), 64'd0);
            chk("t3_din_held", 64'(fifo_din), 64'(word(0, 2)));
            @(posedge WCLK);
            #1;
        end
        fifo_full = 1'b0;
        repeat (10) cycle();
        chk("t3_drained", 64'(exp_q.size()), 64'd0);
        chk("t3_wr_count", 64'(wr_count), 64'd16);

        // T4: lone requester 2 streams back to back; pointer ends at 3
        for (int s = 0; s < 10; s++) begin
            load(2, s);
            expw(2, s);
        end
        cycle();
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("t4_we_stream", 64'(last_we), 64'd1);
        end
        chk("t4_drained", 64'(exp_q.size()), 64'd0);
        for (int id = 0; id < N; id++) load(id, 20);
        expw(3, 20);
        expw(0, 20);
        expw(1, 20);
        expw(2, 20);
        repeat (6) cycle();
        chk("t4_rr_order_drained", 64'(exp_q.size()), 64'd0);
`else
        // T5: bursts of 4; requester 1 runs dry after 2 words and hands over to 2
        for (int s = 0; s < 4; s++) begin
            load(0, s);
            load(2, s);
            load(3, s);
        end
        load(1, 0);
        load(1, 1);
        for (int s = 0; s < 4; s++) expw(0, s);
        expw(1, 0);
        expw(1, 1);
        for (int s = 0; s < 4; s++) expw(2, s);
        for (int s = 0; s < 4; s++) expw(3, s);
        repeat (25) cycle();
        chk("t5_drained", 64'(exp_q.size()), 64'd0);
        chk("t5_wr_count", 64'(wr_count), 64'd14);
`endif

        // T6: reset pulse while a word is stuck behind a full FIFO
        load(1, 30);
        cycle();
        fifo_full = 1'b1;
        RST       = 1'b1;
        @(negedge WCLK);
        chk("t6_we_full", 64'(fifo_we), 64'd0);
        @(posedge WCLK);
        #1;
        RST       = 1'b0;
        fifo_full = 1'b0;
        @(negedge WCLK);
        chk("t6_we_after_rst", 64'(fifo_we), 64'd0);
        chk("t6_wr_count", 64'(wr_count), 64'd0);
        @(posedge WCLK);
        #1;
        for (int id = 0; id < N; id++) begin
            load(id, 50);
            expw(id, 50);
        end
        repeat (12) cycle();
        chk("t6_restart_drained", 64'(exp_q.size()), 64'd0);
        chk("t6_wr_count_after", 64'(wr_count), 64'd4);

        // T7: no grant while RST is high, even with room and a valid request
        load(2, 40);
        RST = 1'b1;
        @(negedge WCLK);
        chk("t7_ready_in_rst", 64'(req_ready), 64'd0);
        chk("t7_we_in_rst", 64'(fifo_we), 64'd0);
        @(posedge WCLK);
        #1;
        RST = 1'b0;
        expw(2, 40);
        repeat (4) cycle();
        chk("t7_drained", 64'(exp_q.size()), 64'd0);
        chk("t7_wr_count", 64'(wr_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
